// File: rtl/galaksija_vram_arbiter_if.sv
// Bundle of requester, CPU and RAM-side signals around the Galaksija video RAM arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM data return.
interface galaksija_vram_arbiter_if #(
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 8
);
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_code;
   logic          vid_valid;

   logic          cpu_rd;
   logic          cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic [DW-1:0] cpu_dout;
   logic          wait_n;

   logic          dl_wr;
   logic [AW-1:0] dl_addr;
   logic [DW-1:0] dl_data;
   logic          dl_ack;

   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_din,
             dl_wr, dl_addr, dl_data, ram_dout,
      output vid_code, vid_valid, cpu_dout, wait_n, dl_ack,
             ram_addr, ram_din, ram_we
   );

   modport master (
      output vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_din,
             dl_wr, dl_addr, dl_data, ram_dout,
      input  vid_code, vid_valid, cpu_dout, wait_n, dl_ack,
             ram_addr, ram_din, ram_we
   );
endinterface

// File: rtl/galaksija_vram_arbiter.sv
// Single-port arbiter for the Galaksija character RAM: video (fixed latency) > download > CPU,
// with a burst limit so continuous downloads cannot starve a stalled CPU forever.
module galaksija_vram_arbiter #(
   parameter int unsigned AW       = 11,
   parameter int unsigned DW       = 8,
   parameter int unsigned DL_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   galaksija_vram_arbiter_if.slave   bus
);
   localparam int unsigned SW = $clog2(DL_BURST + 1);

   typedef enum logic [1:0] {C_IDLE, C_PEND, C_DATA, C_HOLD} cpu_state_e;

   cpu_state_e    state_q;
   logic [AW-1:0] cpu_addr_q;
   logic [DW-1:0] cpu_din_q;
   logic          cpu_we_q;
   logic [DW-1:0] cpu_dout_q;
   logic          vid_s1_q;
   logic          vid_valid_q;
   logic [DW-1:0] vid_code_q;
   logic          dl_ack_q;
   logic [SW-1:0] streak_q;
   logic [SW-1:0] streak_d;

   logic cpu_req;
   logic cpu_live;
   logic dl_live;
   logic vid_gnt;
   logic dl_gnt;
   logic cpu_gnt;

   // Grant for the current cycle; everything is held off while reset is high.
   always_comb begin
      cpu_req  = bus.cpu_rd | bus.cpu_wr;
      cpu_live = !reset && (state_q == C_PEND) && cpu_req;
      dl_live  = !reset && bus.dl_wr && !dl_ack_q;
      vid_gnt  = !reset && bus.vid_req;
      dl_gnt   = 1'b0;
      cpu_gnt  = 1'b0;
      if (!vid_gnt) begin
         if (dl_live && cpu_live) begin
            if (streak_q == SW'(DL_BURST)) cpu_gnt = 1'b1;
            else                           dl_gnt  = 1'b1;
         end else begin
            dl_gnt  = dl_live;
            cpu_gnt = cpu_live;
         end
      end
   end

   // Consecutive download wins against a waiting CPU, saturating at the burst limit.
   always_comb begin
      streak_d = streak_q;
      if ((state_q != C_PEND) || !cpu_req || cpu_gnt)
         streak_d = '0;
      else if (dl_gnt && (streak_q != SW'(DL_BURST)))
         streak_d = streak_q + SW'(1);
   end

   // RAM port mux; idle cycles park the address on the video address.
   always_comb begin
      bus.ram_addr = bus.vid_addr;
      bus.ram_din  = '0;
      bus.ram_we   = 1'b0;
      if (dl_gnt) begin
         bus.ram_addr = bus.dl_addr;
         bus.ram_din  = bus.dl_data;
         bus.ram_we   = 1'b1;
      end else if (cpu_gnt) begin
         bus.ram_addr = cpu_addr_q;
         bus.ram_din  = cpu_din_q;
         bus.ram_we   = cpu_we_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= C_IDLE;
         cpu_addr_q  <= '0;
         cpu_din_q   <= '0;
         cpu_we_q    <= 1'b0;
         cpu_dout_q  <= '0;
         vid_s1_q    <= 1'b0;
         vid_valid_q <= 1'b0;
         vid_code_q  <= '0;
         dl_ack_q    <= 1'b0;
         streak_q    <= '0;
      end else begin
         vid_s1_q    <= vid_gnt;
         vid_valid_q <= vid_s1_q;
         if (vid_s1_q) vid_code_q <= bus.ram_dout;
         dl_ack_q    <= dl_gnt;
         streak_q    <= streak_d;

         case (state_q)
            C_IDLE: begin
               if (cpu_req) begin
                  cpu_addr_q <= bus.cpu_addr;
                  cpu_din_q  <= bus.cpu_din;
                  cpu_we_q   <= bus.cpu_wr;
                  state_q    <= C_PEND;
               end
            end
            C_PEND: begin
               // A request withdrawn before its slot is abandoned without touching RAM.
               if (!cpu_req)     state_q <= C_IDLE;
               else if (cpu_gnt) state_q <= C_DATA;
            end
            C_DATA: begin
               if (!cpu_we_q) cpu_dout_q <= bus.ram_dout;
               state_q <= C_HOLD;
            end
            C_HOLD: begin
               if (!cpu_req) state_q <= C_IDLE;
            end
            default: state_q <= C_IDLE;
         endcase
      end
   end

   assign bus.wait_n    = reset | !(cpu_req && (state_q != C_HOLD));
   assign bus.cpu_dout  = cpu_dout_q;
   assign bus.vid_code  = vid_code_q;
   assign bus.vid_valid = vid_valid_q;
   assign bus.dl_ack    = dl_ack_q;

endmodule
